coin_sequencer: RTL and testbench

- Front-end controller between the three raw coin-slot sensors and the vending_machine FSM.
- Edge-detects slot activity and buffers coins in a small FIFO, highest denomination first when several arrive together.
- Replays buffered coins to the FSM as single-cycle one-hot pulses, each followed by a mandatory idle cycle.
- Sequences the dispense hold and pays out change as discrete unit pulses.

---
 rtl/coin_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_coin_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_sequencer.sv
// coin_sequencer: front end between the raw coin-slot sensors and the
// vending_machine FSM. Rising edges on the slot sensors are queued in a small
// FIFO, highest denomination first when several arrive together. Queued coins
// are replayed to the vending FSM as one-hot single-cycle pulses, each followed
// by an idle cycle. After a dispense the block holds vend_busy, then pays out
// change as discrete unit pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a queued coin; pops the FIFO head into cur_coin
// S_ISSUE   | registers the one-hot coin pulse for the following cycle
// S_GAP     | coin pulse visible; samples d/r from the vending FSM
// S_HOLD    | vend_busy high while the hold timer counts down
// S_CHG_ON  | change_pulse high for one unit coin
// S_CHG_OFF | change_pulse low; more change pending or back to idle
module coin_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 2,
  parameter int VEND_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] slot_in,
  input  logic       d,
  input  logic [2:0] r,
  output logic       one,
  output logic       two,
  output logic       five,
  output logic       vend_busy,
  output logic       change_pulse,
  output logic       fifo_full,
  output logic       coin_reject
);

  // Hold timer must represent VEND_CYCLES-1; keep at least one bit.
  localparam int HOLD_W = (VEND_CYCLES > 2) ? $clog2(VEND_CYCLES) : 1;

  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_TWO  = 2'b10;
  localparam logic [1:0] CODE_FIVE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_HOLD,
    S_CHG_ON,
    S_CHG_OFF
  } state_t;

  // Slot capture
  logic [2:0]        r_slot_prev;
  logic              r_armed;
  logic [2:0]        r_pending;
  logic              r_coin_reject;

  // Coin queue
  logic [1:0]        r_fifo [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Replay FSM
  state_t            r_state;
  logic [1:0]        r_cur_coin;
  logic [2:0]        r_change_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_one;
  logic              r_two;
  logic              r_five;
  logic              r_vend_busy;
  logic              r_change_pulse;

  logic [2:0]        w_edge;
  logic [2:0]        w_req;
  logic [2:0]        w_req_rest;
  logic [1:0]        w_wr_code;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_merge_loss;

  // r_armed gates edge detection for the first cycle after reset so that
  // sensors already high while in reset are not mistaken for new coins.
  assign w_edge       = slot_in & ~r_slot_prev & {3{r_armed}};
  assign w_req        = r_pending | w_edge;
  assign w_merge_loss = |(w_edge & r_pending);
  assign w_full       = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  // A full queue still accepts a write in the same cycle the FSM pops it.
  assign w_push       = (w_req != 3'b000) && (!w_full || w_pop);

  // Pick the highest denomination from the request set; the rest stays pending.
  always_comb begin
    w_wr_code  = 2'b00;
    w_req_rest = w_req;
    if (w_req[2]) begin
      w_wr_code     = CODE_FIVE;
      w_req_rest[2] = 1'b0;
    end else if (w_req[1]) begin
      w_wr_code     = CODE_TWO;
      w_req_rest[1] = 1'b0;
    end else if (w_req[0]) begin
      w_wr_code     = CODE_ONE;
      w_req_rest[0] = 1'b0;
    end
  end

  // Sensor history, pending coins and the coin-lost pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_prev   <= 3'b000;
      r_armed       <= 1'b0;
      r_pending     <= 3'b000;
      r_coin_reject <= 1'b0;
    end else begin
      r_slot_prev   <= slot_in;
      r_armed       <= 1'b1;
      r_pending     <= w_push ? w_req_rest : w_req;
      r_coin_reject <= w_merge_loss;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= 2'b00;
      end
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= w_wr_code;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Replay FSM with registered coin, busy and change outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cur_coin     <= 2'b00;
      r_change_cnt   <= 3'd0;
      r_hold_cnt     <= '0;
      r_one          <= 1'b0;
      r_two          <= 1'b0;
      r_five         <= 1'b0;
      r_vend_busy    <= 1'b0;
      r_change_pulse <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_coin <= r_fifo[r_rd_ptr];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_one   <= (r_cur_coin == CODE_ONE);
          r_two   <= (r_cur_coin == CODE_TWO);
          r_five  <= (r_cur_coin == CODE_FIVE);
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_one  <= 1'b0;
          r_two  <= 1'b0;
          r_five <= 1'b0;
          if (d) begin
            r_change_cnt <= r;
            r_hold_cnt   <= HOLD_W'(VEND_CYCLES - 1);
            r_vend_busy  <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_vend_busy <= 1'b0;
            if (r_change_cnt != 3'd0) begin
              r_change_pulse <= 1'b1;
              r_state        <= S_CHG_ON;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        S_CHG_ON: begin
          r_change_pulse <= 1'b0;
          r_change_cnt   <= r_change_cnt - 3'd1;
          r_state        <= S_CHG_OFF;
        end
        S_CHG_OFF: begin
          if (r_change_cnt != 3'd0) begin
            r_change_pulse <= 1'b1;
            r_state        <= S_CHG_ON;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_one          <= 1'b0;
          r_two          <= 1'b0;
          r_five         <= 1'b0;
          r_vend_busy    <= 1'b0;
          r_change_pulse <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign one          = r_one;
  assign two          = r_two;
  assign five         = r_five;
  assign vend_busy    = r_vend_busy;
  assign change_pulse = r_change_pulse;
  assign coin_reject  = r_coin_reject;
  assign fifo_full    = w_full;

endmodule

// File: tb/tb_coin_sequencer.sv
// Directed bench for coin_sequencer. A tiny vending-FSM model answers d=1
// on a chosen coin pulse (counted from the start of each scenario) with a
// fixed change amount. Observations are sampled 1 ns after each rising edge
// and collected as per-cycle bit masks indexed by cycles since stimulus start.
module tb_coin_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] slot_in = 3'b000;
  logic       d;
  logic [2:0] r;
  logic       one, two, five, vend_busy, change_pulse, fifo_full, coin_reject;

  int         checks = 0;
  int         failures = 0;
  int         pulse_cnt = 0;
  int         d_target = 0;
  logic [2:0] r_val = 3'd0;

  coin_sequencer #(.FIFO_DEPTH(4), .ADDR_W(2), .VEND_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .slot_in(slot_in), .d(d), .r(r),
    .one(one), .two(two), .five(five), .vend_busy(vend_busy),
    .change_pulse(change_pulse), .fifo_full(fifo_full), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  // Vending FSM model: dispense on the d_target-th coin pulse overall.
  assign d = (one | two | five) && (pulse_cnt + 1 == d_target);
  assign r = r_val;

  always @(posedge clk) begin
    if (one | two | five) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] act;
    reset = 1'b1;
    slot_in = 3'b111;
    repeat (3) tick();
    checks++;
    if ({one, two, five, vend_busy, change_pulse, fifo_full, coin_reject} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {one, two, five, vend_busy, change_pulse, fifo_full, coin_reject}, 7'b0);
    end
    reset = 1'b0;
    act = 7'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      act |= {one, two, five, vend_busy, change_pulse, fifo_full, coin_reject};
    end
    checks++;
    if (act !== 7'b0) begin
      failures++;
      $display("FAIL reset_no_capture got=%b exp=%b", act, 7'b0);
    end
    slot_in = 3'b000;
    act = 7'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      act |= {one, two, five, vend_busy, change_pulse, fifo_full, coin_reject};
    end
    checks++;
    if (act !== 7'b0) begin
      failures++;
      $display("FAIL reset_fall_quiet got=%b exp=%b", act, 7'b0);
    end
  endtask

  task automatic test_single_ones();
    logic [63:0] one_m, other_m, busy_m, chg_m;
    one_m = '0; other_m = '0; busy_m = '0; chg_m = '0;
    d_target = pulse_cnt + 5;
    r_val = 3'd0;
    for (int i = 0; i < 40; i++) begin
      slot_in = (i < 20 && i % 4 == 0) ? 3'b001 : 3'b000;
      tick();
      one_m[i+1]   = one;
      other_m[i+1] = two | five;
      busy_m[i+1]  = vend_busy;
      chg_m[i+1]   = change_pulse;
    end
    checks++;
    if (one_m !== ((64'h1 << 3) | (64'h1 << 7) | (64'h1 << 11) | (64'h1 << 15) | (64'h1 << 19))) begin
      failures++;
      $display("FAIL single_one_pulses got=%h exp=%h", one_m,
               (64'h1 << 3) | (64'h1 << 7) | (64'h1 << 11) | (64'h1 << 15) | (64'h1 << 19));
    end
    checks++;
    if (other_m !== 64'h0) begin
      failures++;
      $display("FAIL single_other_coins got=%h exp=0", other_m);
    end
    checks++;
    if ((one_m & (one_m << 1)) !== 64'h0) begin
      failures++;
      $display("FAIL single_idle_gap got=%h exp=0", one_m & (one_m << 1));
    end
    checks++;
    if (busy_m !== ((64'h1 << 20) | (64'h1 << 21) | (64'h1 << 22))) begin
      failures++;
      $display("FAIL single_vend_busy got=%h exp=%h", busy_m,
               (64'h1 << 20) | (64'h1 << 21) | (64'h1 << 22));
    end
    checks++;
    if (chg_m !== 64'h0) begin
      failures++;
      $display("FAIL single_no_change got=%h exp=0", chg_m);
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] m1, m2, m5;
    m1 = '0; m2 = '0; m5 = '0;
    d_target = pulse_cnt + 100;
    for (int i = 0; i < 16; i++) begin
      slot_in = (i < 6) ? 3'b111 : 3'b000;
      tick();
      m1[i+1] = one;
      m2[i+1] = two;
      m5[i+1] = five;
    end
    checks++;
    if (m5 !== (64'h1 << 3)) begin
      failures++;
      $display("FAIL simul_five got=%h exp=%h", m5, 64'h1 << 3);
    end
    checks++;
    if (m2 !== (64'h1 << 6)) begin
      failures++;
      $display("FAIL simul_two got=%h exp=%h", m2, 64'h1 << 6);
    end
    checks++;
    if (m1 !== (64'h1 << 9)) begin
      failures++;
      $display("FAIL simul_one got=%h exp=%h", m1, 64'h1 << 9);
    end
  endtask

  task automatic test_change();
    logic [63:0] m1, m2, m5, busy_m, chg_m;
    m1 = '0; m2 = '0; m5 = '0; busy_m = '0; chg_m = '0;
    d_target = pulse_cnt + 3;
    r_val = 3'd2;
    for (int i = 0; i < 28; i++) begin
      case (i)
        0, 2:    slot_in = 3'b001;
        4:       slot_in = 3'b100;
        20:      slot_in = 3'b010;
        default: slot_in = 3'b000;
      endcase
      tick();
      m1[i+1]     = one;
      m2[i+1]     = two;
      m5[i+1]     = five;
      busy_m[i+1] = vend_busy;
      chg_m[i+1]  = change_pulse;
    end
    checks++;
    if (m1 !== ((64'h1 << 3) | (64'h1 << 6))) begin
      failures++;
      $display("FAIL change_ones got=%h exp=%h", m1, (64'h1 << 3) | (64'h1 << 6));
    end
    checks++;
    if (m5 !== (64'h1 << 9)) begin
      failures++;
      $display("FAIL change_five got=%h exp=%h", m5, 64'h1 << 9);
    end
    checks++;
    if (busy_m !== ((64'h1 << 10) | (64'h1 << 11) | (64'h1 << 12))) begin
      failures++;
      $display("FAIL change_busy got=%h exp=%h", busy_m,
               (64'h1 << 10) | (64'h1 << 11) | (64'h1 << 12));
    end
    checks++;
    if (chg_m !== ((64'h1 << 13) | (64'h1 << 15))) begin
      failures++;
      $display("FAIL change_pulses got=%h exp=%h", chg_m, (64'h1 << 13) | (64'h1 << 15));
    end
    checks++;
    if (m2 !== (64'h1 << 23)) begin
      failures++;
      $display("FAIL change_back_idle got=%h exp=%h", m2, 64'h1 << 23);
    end
  endtask

  task automatic test_full();
    logic [63:0] m1, m2, full_m, rej_m, chg_m, busy_m, exp_full, exp_chg;
    m1 = '0; m2 = '0; full_m = '0; rej_m = '0; chg_m = '0; busy_m = '0;
    d_target = pulse_cnt + 1;
    r_val = 3'd7;
    for (int i = 0; i < 44; i++) begin
      if (i == 0) slot_in = 3'b010;
      else if (i >= 5 && i <= 15 && (i % 2 == 1)) slot_in = 3'b001;
      else slot_in = 3'b000;
      tick();
      m1[i+1]     = one;
      m2[i+1]     = two;
      full_m[i+1] = fifo_full;
      rej_m[i+1]  = coin_reject;
      chg_m[i+1]  = change_pulse;
      busy_m[i+1] = vend_busy;
    end
    exp_full = ((64'h1 << 25) - 64'h1) & ~((64'h1 << 12) - 64'h1);
    exp_chg = '0;
    for (int k = 0; k < 7; k++) exp_chg[7 + 2*k] = 1'b1;
    checks++;
    if (m2 !== (64'h1 << 3)) begin
      failures++;
      $display("FAIL full_trigger_two got=%h exp=%h", m2, 64'h1 << 3);
    end
    checks++;
    if (busy_m !== ((64'h1 << 4) | (64'h1 << 5) | (64'h1 << 6))) begin
      failures++;
      $display("FAIL full_busy got=%h exp=%h", busy_m, (64'h1 << 4) | (64'h1 << 5) | (64'h1 << 6));
    end
    checks++;
    if (chg_m !== exp_chg) begin
      failures++;
      $display("FAIL full_change7 got=%h exp=%h", chg_m, exp_chg);
    end
    checks++;
    if (full_m !== exp_full) begin
      failures++;
      $display("FAIL full_flag got=%h exp=%h", full_m, exp_full);
    end
    checks++;
    if (rej_m !== (64'h1 << 16)) begin
      failures++;
      $display("FAIL full_reject got=%h exp=%h", rej_m, 64'h1 << 16);
    end
    checks++;
    if (m1 !== ((64'h1 << 23) | (64'h1 << 26) | (64'h1 << 29) | (64'h1 << 32) | (64'h1 << 35))) begin
      failures++;
      $display("FAIL full_drain got=%h exp=%h", m1,
               (64'h1 << 23) | (64'h1 << 26) | (64'h1 << 29) | (64'h1 << 32) | (64'h1 << 35));
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  act;
    logic [63:0] m5;
    d_target = pulse_cnt + 1;
    r_val = 3'd3;
    for (int i = 0; i < 7; i++) begin
      slot_in = (i == 0) ? 3'b001 : (i == 4) ? 3'b010 : 3'b000;
      tick();
    end
    checks++;
    if (change_pulse !== 1'b1) begin
      failures++;
      $display("FAIL mid_chg_on got=%b exp=1", change_pulse);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({one, two, five, vend_busy, change_pulse, fifo_full, coin_reject} !== 7'b0) begin
      failures++;
      $display("FAIL mid_async_clear got=%b exp=%b",
               {one, two, five, vend_busy, change_pulse, fifo_full, coin_reject}, 7'b0);
    end
    repeat (2) tick();
    reset = 1'b0;
    act = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      act |= {one, two, five, vend_busy, change_pulse};
    end
    checks++;
    if (act !== 5'b0) begin
      failures++;
      $display("FAIL mid_flushed got=%b exp=%b", act, 5'b0);
    end
    m5 = '0;
    for (int i = 0; i < 8; i++) begin
      slot_in = (i == 0) ? 3'b100 : 3'b000;
      tick();
      m5[i+1] = five;
    end
    checks++;
    if (m5 !== (64'h1 << 3)) begin
      failures++;
      $display("FAIL mid_idle_after got=%h exp=%h", m5, 64'h1 << 3);
    end
  endtask

  initial begin
    test_reset();
    test_single_ones();
    test_simultaneous();
    test_change();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
